// File: rtl/dcim_bitserial_mac_if.sv
// dcim_bitserial_mac_if: beat stream from the CIM array read-out and the result stream to requant.
interface dcim_bitserial_mac_if #(
    parameter int NUM_CH   = 4,
    parameter int NUM_ELEM = 32,
    parameter int ELEM_W   = 4,
    parameter int NUM_BITS = 4
);
    localparam int OUT_W = ELEM_W + $clog2(NUM_ELEM) + NUM_BITS;
    logic                             in_valid;
    logic [NUM_CH*NUM_ELEM*ELEM_W-1:0] in_data;
    logic                             in_signed;
    logic                             in_clear;
    logic                             out_valid;
    logic [NUM_CH*OUT_W-1:0]          out_data;
    modport master (output in_valid, in_data, in_signed, in_clear, input out_valid, out_data);
    modport slave (input in_valid, in_data, in_signed, in_clear, output out_valid, out_data);
endinterface

// File: rtl/dcim_bitserial_mac.sv
// dcim_bitserial_mac: per-channel pipelined adder tree feeding an MSB-first shift-accumulate.
module dcim_bitserial_mac #(
    parameter int NUM_CH   = 4,
    parameter int NUM_ELEM = 32,
    parameter int ELEM_W   = 4,
    parameter int NUM_BITS = 4
) (
    input logic clk,
    input logic rst_n,
    dcim_bitserial_mac_if.slave bus
);
    localparam int L     = $clog2(NUM_ELEM);
    localparam int SUM_W = ELEM_W + L;
    localparam int OUT_W = SUM_W + NUM_BITS;
    localparam int CW    = $clog2(NUM_BITS);

    logic [L:0]       vld;
    logic [L:0]       sgn;
    logic [CW-1:0]    cnt;
    logic             acc_done;
    logic [OUT_W-1:0] acc [NUM_CH];

    // level 0 is the input register; level k holds NUM_ELEM>>k partial sums of ELEM_W+k bits
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int N = NUM_ELEM >> k;
        localparam int W = ELEM_W + k;
        logic [W-1:0] s [NUM_CH][N];
        if (k == 0) begin : g_in
            always_ff @(posedge clk)
                for (int c = 0; c < NUM_CH; c++)
                    for (int e = 0; e < N; e++)
                        s[c][e] <= bus.in_data[(c*NUM_ELEM+e)*ELEM_W +: ELEM_W];
        end else begin : g_add
            always_ff @(posedge clk)
                for (int c = 0; c < NUM_CH; c++)
                    for (int e = 0; e < N; e++)
                        s[c][e] <= {1'b0, g_lvl[k-1].s[c][2*e]} + {1'b0, g_lvl[k-1].s[c][2*e+1]};
        end
    end

    always_ff @(posedge clk)
        sgn <= {sgn[L-1:0], bus.in_signed};

    // beat 0 restarts the accumulator, so back-to-back groups never see the previous result
    always_ff @(posedge clk)
        if (vld[L])
            for (int c = 0; c < NUM_CH; c++)
                acc[c] <= cnt != '0 ? (acc[c] << 1) + OUT_W'(g_lvl[L].s[c][0])
                        : sgn[L] ? -OUT_W'(g_lvl[L].s[c][0]) : OUT_W'(g_lvl[L].s[c][0]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld           <= '0;
            cnt           <= '0;
            acc_done      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            vld           <= bus.in_clear ? '0 : {vld[L-1:0], bus.in_valid};
            cnt           <= bus.in_clear ? '0
                           : vld[L] ? (cnt == CW'(NUM_BITS-1) ? '0 : cnt + 1'b1) : cnt;
            acc_done      <= ~bus.in_clear & vld[L] & (cnt == CW'(NUM_BITS-1));
            bus.out_valid <= acc_done;
            for (int c = 0; c < NUM_CH; c++)
                bus.out_data[c*OUT_W +: OUT_W] <= acc_done ? acc[c] : '0;
        end
endmodule

// File: tb/tb_dcim_bitserial_mac.sv
// tb_dcim_bitserial_mac: scoreboard bench; expected results queued at stimulus time, popped on out_valid.
module tb_dcim_bitserial_mac;
    localparam int NC    = 4;
    localparam int NE    = 32;
    localparam int EW    = 4;
    localparam int NB    = 4;
    localparam int OUT_W = EW + $clog2(NE) + NB;
    localparam int DW    = NC*NE*EW;
    localparam int OW    = NC*OUT_W;
    localparam int LAT   = $clog2(NE) + 3;

    typedef struct { logic [OW-1:0] d; int c; } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int cyc = 0;
    int last_cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [DW-1:0] b [NB];

    dcim_bitserial_mac_if #(.NUM_CH(NC), .NUM_ELEM(NE), .ELEM_W(EW), .NUM_BITS(NB)) bus();
    dcim_bitserial_mac #(.NUM_CH(NC), .NUM_ELEM(NE), .ELEM_W(EW), .NUM_BITS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // kind: 0 all 0xF, 1 ch c = c+1, 2 only ch0 elem0 = 1, 3 zero, 4 random
    function automatic logic [DW-1:0] pat(input int kind);
        logic [DW-1:0] d = '0;
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < NE; i++)
                d[(c*NE+i)*EW +: EW] = kind == 0 ? {EW{1'b1}} : kind == 1 ? EW'(c+1)
                                     : kind == 4 ? EW'($urandom) : '0;
        if (kind == 2) d[EW-1:0] = 1;
        return d;
    endfunction

    function automatic logic [OW-1:0] rep(input int v);
        logic [OW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*OUT_W +: OUT_W] = OUT_W'(v);
        return r;
    endfunction

    // weighted bit-plane sum; signed groups give the MSB plane weight -2^(NB-1)
    function automatic logic [OW-1:0] ref_out(input logic [DW-1:0] bb [NB], input logic s);
        logic [OW-1:0] r;
        longint v;
        longint t;
        for (int c = 0; c < NC; c++) begin
            v = 0;
            for (int i = 0; i < NB; i++) begin
                t = 0;
                for (int j = 0; j < NE; j++) t += longint'(bb[i][(c*NE+j)*EW +: EW]);
                v += (i == 0 && s) ? -(t * (64'sd1 << (NB-1))) : t * (64'sd1 << (NB-1-i));
            end
            r[c*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        return r;
    endfunction

    task automatic beat(input logic v, input logic [DW-1:0] d, input logic s, input logic clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_clear  = clr;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(0, '0, 0, 0);
    endtask

    task automatic push(input logic [OW-1:0] d);
        exp_q.push_back('{d: d, c: last_cyc + LAT});
    endtask

    always @(negedge clk) begin
        if (!rst_n || !bus.out_valid)
            chk("idle_out", 64'({bus.out_valid, bus.out_data}), 64'd0);
        else begin
            chk("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", 64'(bus.out_data), 64'(e.d));
                chk("latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    initial begin
        logic [OW-1:0] p;
        bus.in_valid = 0; bus.in_data = '0; bus.in_signed = 0; bus.in_clear = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);
        repeat (NB) beat(1, pat(0), 0, 0);
        push(rep(7200));
        idle(12);
        // signed then unsigned back-to-back; in_signed toggled on non-zero beats must be ignored
        beat(1, pat(2), 1, 0);
        repeat (NB-1) beat(1, pat(3), 0, 0);
        push(OW'(13'h1FF8));
        beat(1, pat(2), 0, 0);
        repeat (NB-1) beat(1, pat(3), 1, 0);
        push(OW'(8));
        idle(12);
        beat(1, pat(0), 0, 0);
        beat(1, pat(0), 0, 0);
        idle(3);
        beat(1, pat(0), 0, 0);
        beat(1, pat(0), 0, 0);
        push(rep(7200));
        idle(12);
        for (int c = 0; c < NC; c++) p[c*OUT_W +: OUT_W] = OUT_W'(480*(c+1));
        for (int i = 0; i < 2*NB; i++) begin
            beat(1, pat(1), 0, 0);
            if (i % NB == NB-1) push(p);
        end
        idle(12);
        beat(1, pat(0), 0, 0);
        beat(1, pat(0), 0, 0);
        beat(1, pat(0), 0, 1);
        repeat (NB) beat(1, pat(0), 0, 0);
        push(rep(7200));
        idle(12);
        beat(1, pat(0), 1, 0);
        beat(1, pat(0), 0, 0);
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        repeat (NB) beat(1, pat(0), 0, 0);
        push(rep(7200));
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < NB; i++) b[i] = pat(g == 0 ? 0 : 4);
            for (int i = 0; i < NB; i++) beat(1, b[i], i == 0 ? g[0] : 1'($urandom), 0);
            push(ref_out(b, g[0]));
        end
        idle(15);
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
